// File: rtl/fp32_mul_hs.sv
// fp32_mul_hs: IEEE-754 binary32 multiplier, stb/ack responder, multi-cycle FSM
//   iClk, iRstn          : clock, async active-low reset
//   data_a/a_stb/a_ack   : operand A handshake
//   data_b/b_stb/b_ack   : operand B handshake
//   result/z_stb/z_ack   : product handshake (held until z_ack)
module fp32_mul_hs (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic [31:0] data_a,
  input  logic        a_stb,
  output logic        a_ack,
  input  logic [31:0] data_b,
  input  logic        b_stb,
  output logic        b_ack,
  output logic [31:0] result,
  output logic        z_stb,
  input  logic        z_ack
);
  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;
  state_t             state_q, state_d;
  logic        [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        [23:0] a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic        [47:0] prod_q, prod_d;
  logic               sign_q, sign_d, g_q, g_d, r_q, r_d, s_q, s_d;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, round_up;
  logic        [24:0] m_inc;
  logic        [9:0]  z_bias;
  // Exponent field 0 covers denormals too: they are flushed to zero.
  assign a_nan  = &a_q[30:23] & |a_q[22:0];
  assign b_nan  = &b_q[30:23] & |b_q[22:0];
  assign a_inf  = &a_q[30:23] & ~|a_q[22:0];
  assign b_inf  = &b_q[30:23] & ~|b_q[22:0];
  assign a_zero = ~|a_q[30:23];
  assign b_zero = ~|b_q[30:23];
  // Nearest-even: round up above half, or at exactly half when the kept lsb is odd.
  assign round_up = g_q & (r_q | s_q | z_m_q[0]);
  assign m_inc    = {1'b0, z_m_q} + 25'd1;
  assign z_bias   = z_e_q + 10'sd127;
  assign a_ack  = state_q == GET_A;
  assign b_ack  = state_q == GET_B;
  assign z_stb  = state_q == PUT_Z;
  assign result = result_q;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    z_m_d    = z_m_q;
    z_e_d    = z_e_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    result_d = result_q;
    case (state_q)
      GET_A: if (a_stb) begin
        a_d     = data_a;
        state_d = GET_B;
      end
      GET_B: if (b_stb) begin
        b_d     = data_b;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d  = a_q[31] ^ b_q[31];
        a_e_d   = $signed({2'b0, a_q[30:23]}) - 10'sd127;
        b_e_d   = $signed({2'b0, b_q[30:23]}) - 10'sd127;
        a_m_d   = {1'b1, a_q[22:0]};
        b_m_d   = {1'b1, b_q[22:0]};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
          result_d = 32'h7FC0_0000;
        else if (a_inf | b_inf)
          result_d = {sign_q, 8'hFF, 23'd0};
        else if (a_zero | b_zero)
          result_d = {sign_q, 31'd0};
        else
          state_d = MULTIPLY;
      end
      MULTIPLY: begin
        prod_d  = {24'd0, a_m_q} * {24'd0, b_m_q};
        z_e_d   = a_e_q + b_e_q;
        state_d = NORMALISE;
      end
      NORMALISE: begin
        // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
        z_m_d   = prod_q[47] ? prod_q[47:24] : prod_q[46:23];
        g_d     = prod_q[47] ? prod_q[23] : prod_q[22];
        r_d     = prod_q[47] ? prod_q[22] : prod_q[21];
        s_d     = prod_q[47] ? |prod_q[21:0] : |prod_q[20:0];
        z_e_d   = prod_q[47] ? z_e_q + 10'sd1 : z_e_q;
        state_d = ROUND;
      end
      ROUND: begin
        if (round_up) begin
          z_m_d = m_inc[24] ? 24'h80_0000 : m_inc[23:0];
          z_e_d = m_inc[24] ? z_e_q + 10'sd1 : z_e_q;
        end
        state_d = PACK;
      end
      PACK: begin
        result_d = z_e_q > 10'sd127  ? {sign_q, 8'hFF, 23'd0} :
                   z_e_q < -10'sd126 ? {sign_q, 31'd0} :
                                       {sign_q, z_bias[7:0], z_m_q[22:0]};
        state_d  = PUT_Z;
      end
      PUT_Z: if (z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q  <= GET_A;
      a_q      <= '0;
      b_q      <= '0;
      a_m_q    <= '0;
      b_m_q    <= '0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      z_m_q    <= '0;
      z_e_q    <= '0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      z_m_q    <= z_m_d;
      z_e_q    <= z_e_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      result_q <= result_d;
    end
  end
endmodule
